// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper.
// Holds score width/limit, FSM state and winner encodings.
package score_pkg;

  localparam int SCORE_W = 6;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 6'd63;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    ROUND_END,
    GAME_OVER
  } score_state_t;

  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_P1,
    WIN_P2,
    WIN_DRAW
  } winner_t;

endpackage

// File: rtl/score_counter.sv
// Saturating score counter with clear and increment enable.
// Ports: clk, rst, clear, incr in; count (registered), next (comb) out.
module score_counter
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               incr,
  output logic [SCORE_W-1:0] count,
  output logic [SCORE_W-1:0] next
);

  // next is the value count takes on this edge absent a clear; the
  // keeper uses it to judge the win on the same tick as the increment.
  assign next = (incr && count != SCORE_MAX) ? count + 6'd1 : count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= next;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Turns hit pulses into frame-aligned player scores and runs game flow.
// Ports: clk_i, rst_i, frame_tick_i, new_game_i, hit_player_1_i,
//   hit_player_2_i in; score_player_1_o/2_o, round_reset_o,
//   game_over_o, winner_o out.
// Build option: SCORE_KEEPER_ROUND_DELAY_EN adds the ROUND_END pause.
module score_keeper
  import score_pkg::*;
#(
  parameter int WIN_SCORE    = 10,
  parameter int ROUND_FRAMES = 60
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_tick_i,
  input  logic               new_game_i,
  input  logic               hit_player_1_i,
  input  logic               hit_player_2_i,
  output logic [SCORE_W-1:0] score_player_1_o,
  output logic [SCORE_W-1:0] score_player_2_o,
  output logic               round_reset_o,
  output logic               game_over_o,
  output logic [1:0]         winner_o
);

  if (WIN_SCORE < 1 || WIN_SCORE > 63) begin : g_bad_win
    $error("score_keeper: WIN_SCORE out of range 1..63");
  end
  if (ROUND_FRAMES < 1 || ROUND_FRAMES > 255) begin : g_bad_frames
    $error("score_keeper: ROUND_FRAMES out of range 1..255");
  end

  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  score_state_t       state;
  logic               pend_1;
  logic               pend_2;
  logic               want_1;
  logic               want_2;
  logic               score_tick;
  logic               win_1;
  logic               win_2;
  logic [SCORE_W-1:0] next_1;
  logic [SCORE_W-1:0] next_2;

`ifdef SCORE_KEEPER_ROUND_DELAY_EN
  localparam logic [7:0] RF_LAST = 8'(ROUND_FRAMES - 1);
  logic [7:0] frame_cnt;
`endif

  // A hit in the same cycle as the tick still counts.
  assign want_1 = pend_1 | hit_player_2_i;
  assign want_2 = pend_2 | hit_player_1_i;

  assign score_tick = (state == PLAY) && frame_tick_i
                   && (want_1 || want_2) && !new_game_i;

  assign win_1 = next_1 >= WIN_S;
  assign win_2 = next_2 >= WIN_S;

  score_counter u_score_1 (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (new_game_i),
    .incr  (score_tick & want_1),
    .count (score_player_1_o),
    .next  (next_1)
  );

  score_counter u_score_2 (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (new_game_i),
    .incr  (score_tick & want_2),
    .count (score_player_2_o),
    .next  (next_2)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      pend_1        <= 1'b0;
      pend_2        <= 1'b0;
      round_reset_o <= 1'b0;
      game_over_o   <= 1'b0;
      winner_o      <= WIN_NONE;
`ifdef SCORE_KEEPER_ROUND_DELAY_EN
      frame_cnt     <= '0;
`endif
    end else begin
      round_reset_o <= 1'b0;
      if (new_game_i) begin
        state         <= PLAY;
        pend_1        <= 1'b0;
        pend_2        <= 1'b0;
        round_reset_o <= 1'b1;
        game_over_o   <= 1'b0;
        winner_o      <= WIN_NONE;
`ifdef SCORE_KEEPER_ROUND_DELAY_EN
        frame_cnt     <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: ;
          PLAY: begin
            if (score_tick) begin
              pend_1 <= 1'b0;
              pend_2 <= 1'b0;
              if (win_1 || win_2) begin
                state       <= GAME_OVER;
                game_over_o <= 1'b1;
                // {win_2,win_1} lines up with the winner_t encoding.
                winner_o    <= {win_2, win_1};
              end else begin
`ifdef SCORE_KEEPER_ROUND_DELAY_EN
                state     <= ROUND_END;
                frame_cnt <= '0;
`else
                round_reset_o <= 1'b1;
`endif
              end
            end else begin
              pend_1 <= want_1;
              pend_2 <= want_2;
            end
          end
          ROUND_END: begin
`ifdef SCORE_KEEPER_ROUND_DELAY_EN
            pend_1 <= 1'b0;
            pend_2 <= 1'b0;
            if (frame_tick_i) begin
              if (frame_cnt == RF_LAST) begin
                state         <= PLAY;
                round_reset_o <= 1'b1;
                frame_cnt     <= '0;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
`else
            state <= PLAY;
`endif
          end
          GAME_OVER: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with an expected-output queue.
// Covers both builds of SCORE_KEEPER_ROUND_DELAY_EN.
module tb_score_keeper;

`ifdef SCORE_KEEPER_ROUND_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       ng = 1'b0;
  logic       h1 = 1'b0;
  logic       h2 = 1'b0;
  logic [5:0] s1;
  logic [5:0] s2;
  logic       rr;
  logic       go;
  logic [1:0] win;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [5:0] s1;
    logic [5:0] s2;
    logic       rr;
    logic       go;
    logic [1:0] win;
  } exp_t;

  exp_t exp_q[$];

  score_keeper #(
    .WIN_SCORE    (10),
    .ROUND_FRAMES (60)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .frame_tick_i     (tick),
    .new_game_i       (ng),
    .hit_player_1_i   (h1),
    .hit_player_2_i   (h2),
    .score_player_1_o (s1),
    .score_player_2_o (s2),
    .round_reset_o    (rr),
    .game_over_o      (go),
    .winner_o         (win)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
  endtask

  task automatic push(logic [5:0] e1, logic [5:0] e2,
                      logic err, logic ego, logic [1:0] ewin);
    exp_t e;
    e.s1 = e1;
    e.s2 = e2;
    e.rr = err;
    e.go = ego;
    e.win = ewin;
    exp_q.push_back(e);
  endtask

  task automatic check(string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $error("FAIL %s observed=none expected=queued entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".s1"}, {2'b0, s1}, {2'b0, e.s1});
      chk({tag, ".s2"}, {2'b0, s2}, {2'b0, e.s2});
      chk({tag, ".rr"}, {7'b0, rr}, {7'b0, e.rr});
      chk({tag, ".go"}, {7'b0, go}, {7'b0, e.go});
      chk({tag, ".win"}, {6'b0, win}, {6'b0, e.win});
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic cyc(logic a_ng, logic a_tk, logic a_h1, logic a_h2);
    ng = a_ng;
    tick = a_tk;
    h1 = a_h1;
    h2 = a_h2;
    @(posedge clk);
    #1;
    ng = 1'b0;
    tick = 1'b0;
    h1 = 1'b0;
    h2 = 1'b0;
  endtask

  // Sixty ticks in ROUND_END; only the last one releases play.
  task automatic run_round(logic [5:0] e1, logic [5:0] e2);
    for (int k = 1; k <= 60; k++) begin
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      push(e1, e2, k == 60, 1'b0, 2'd0);
      check($sformatf("round_t%0d", k));
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    push(0, 0, 0, 0, 0);
    check("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: hits in IDLE ignored, then new game
    cyc(0, 1, 1, 1);
    push(0, 0, 0, 0, 0);
    check("idle_hit");
    cyc(1, 0, 0, 0);
    push(0, 0, 1, 0, 0);
    check("new_game");
    cyc(0, 0, 0, 0);
    push(0, 0, 0, 0, 0);
    check("ng_pulse_end");

    // 2: double hit counts once, scored on tick
    cyc(0, 0, 0, 1);
    push(0, 0, 0, 0, 0);
    check("pend_no_tick");
    cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    push(1, 0, !DLY, 0, 0);
    check("p1_score");
`ifdef SCORE_KEEPER_ROUND_DELAY_EN
    run_round(1, 0);
`endif
    cyc(0, 0, 0, 0);
    push(1, 0, 0, 0, 0);
    check("rr_end");
    cyc(0, 1, 0, 0);
    push(1, 0, 0, 0, 0);
    check("pend_cleared");

    // 3: simultaneous hits
    cyc(1, 0, 0, 0);
    push(0, 0, 1, 0, 0);
    check("ng2");
    cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 0);
    push(1, 1, !DLY, 0, 0);
    check("draw_round");
`ifdef SCORE_KEEPER_ROUND_DELAY_EN
    cyc(0, 0, 1, 0);
    run_round(1, 1);
    cyc(0, 1, 0, 0);
    push(1, 1, 0, 0, 0);
    check("hit_in_round_end");
`endif

    // 4: player 1 wins
    cyc(1, 0, 0, 0);
    push(0, 0, 1, 0, 0);
    check("ng3");
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 0, 1);
      push(6'(i), 0, (i < 10) && !DLY, i == 10, (i == 10) ? 2'd1 : 2'd0);
      check($sformatf("p1_run%0d", i));
`ifdef SCORE_KEEPER_ROUND_DELAY_EN
      if (i < 10) run_round(6'(i), 0);
`endif
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 1);
      push(10, 0, 0, 1, 1);
      check("frozen");
    end

    // 5: draw game, then restart
    cyc(1, 0, 0, 0);
    push(0, 0, 1, 0, 0);
    check("ng4");
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 1, 1);
      push(6'(i), 6'(i), (i < 10) && !DLY, i == 10,
           (i == 10) ? 2'd3 : 2'd0);
      check($sformatf("draw_run%0d", i));
`ifdef SCORE_KEEPER_ROUND_DELAY_EN
      if (i < 10) run_round(6'(i), 6'(i));
`endif
    end
    cyc(1, 0, 0, 0);
    push(0, 0, 1, 0, 0);
    check("ng_after_draw");

    // 6: async reset mid-round
    cyc(0, 1, 0, 1);
    push(1, 0, !DLY, 0, 0);
    check("pre_rst");
`ifdef SCORE_KEEPER_ROUND_DELAY_EN
    cyc(0, 1, 0, 0);
    push(1, 0, 0, 0, 0);
    check("in_round_end");
`endif
    #2 rst = 1'b1;
    #1;
    push(0, 0, 0, 0, 0);
    check("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 1, 1, 1);
    push(0, 0, 0, 0, 0);
    check("idle_after_rst");
    cyc(1, 0, 0, 0);
    push(0, 0, 1, 0, 0);
    check("ng_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
